// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-path pipeline of the 5-stage RISC-V core.
//
// Carries the decoded control bundle from ID through the ID->EX, EX->MEM and
// MEM->WB registers, detects load-use hazards (one bubble into EX while PC and
// IF/ID are frozen), freezes the whole back end during multi-cycle data-memory
// accesses, and counts issue cycles lost to either kind of stall.
//
// Parameters
//   CNT_W           width of the saturating stall-cycle counter
// Ports
//   clk_i           core clock, rising edge
//   rst_i           asynchronous reset, active low
//   RegWrite_i ..   ID-stage decoded control (RegWrite, MemtoReg, MemRead,
//   ALUOp_i         MemWrite, ALUSrc, ALUOp)
//   RS1addr_i       ID-stage source register 1
//   RS2addr_i       ID-stage source register 2
//   RDaddr_i        ID-stage destination register
//   MemStall_i      data memory busy; freeze back end this cycle
//   NoOp_o          to decoder: force zero controls (bubble)
//   PCWrite_o       PC update enable
//   Stall_o         IF/ID hold
//   EX_*_o          EX-stage ALUOp, ALUSrc, rd
//   MEM_*_o         MEM-stage MemRead, MemWrite, RegWrite, rd
//   WB_*_o          WB-stage RegWrite, MemtoReg, rd
//   StallCnt_o      cycles with PCWrite_o=0, saturating at all-ones
module ctrl_pipe #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             ALUSrc_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic [4:0]       RDaddr_i,
  input  logic             MemStall_i,
  output logic             NoOp_o,
  output logic             PCWrite_o,
  output logic             Stall_o,
  output logic [1:0]       EX_ALUOp_o,
  output logic             EX_ALUSrc_o,
  output logic [4:0]       EX_RDaddr_o,
  output logic             MEM_MemRead_o,
  output logic             MEM_MemWrite_o,
  output logic             MEM_RegWrite_o,
  output logic [4:0]       MEM_RDaddr_o,
  output logic             WB_RegWrite_o,
  output logic             WB_MemtoReg_o,
  output logic [4:0]       WB_RDaddr_o,
  output logic [CNT_W-1:0] StallCnt_o
);

  typedef struct packed {
    logic       regWrite;
    logic       memtoReg;
    logic       memRead;
    logic       memWrite;
    logic       aluSrc;
    logic [1:0] aluOp;
    logic [4:0] rd;
  } exBundle_t;

  typedef struct packed {
    logic       regWrite;
    logic       memtoReg;
    logic       memRead;
    logic       memWrite;
    logic [4:0] rd;
  } memBundle_t;

  typedef struct packed {
    logic       regWrite;
    logic       memtoReg;
    logic [4:0] rd;
  } wbBundle_t;

  exBundle_t  idBundle;
  exBundle_t  exQ, exD;
  memBundle_t memQ, memD;
  wbBundle_t  wbQ, wbD;

  logic             memStall;
  logic             hazard;
  logic             advance;
  logic             bubble;
  logic [CNT_W-1:0] stallCntQ, stallCntD;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  assign idBundle = '{
    regWrite: RegWrite_i,
    memtoReg: MemtoReg_i,
    memRead:  MemRead_i,
    memWrite: MemWrite_i,
    aluSrc:   ALUSrc_i,
    aluOp:    ALUOp_i,
    rd:       RDaddr_i
  };

  // Masked by reset so the control outputs read "running, empty pipe" while
  // rst_i is low, whatever MemStall_i does.
  assign memStall = MemStall_i & rst_i;

  // x0 is never a real destination, so a load to x0 cannot create a hazard.
  // The bubble carries MemRead=0, which bounds a hazard to one cycle per load.
  assign hazard = exQ.memRead & (exQ.rd != 5'd0) &
                  ((exQ.rd == RS1addr_i) | (exQ.rd == RS2addr_i));

  // Memory stall outranks the load-use hazard; the hazard is simply
  // re-evaluated once the memory releases the pipeline.
  always_comb begin
    advance   = 1'b1;
    bubble    = 1'b0;
    PCWrite_o = 1'b1;
    Stall_o   = 1'b0;
    NoOp_o    = 1'b0;
    if (memStall) begin
      advance   = 1'b0;
      PCWrite_o = 1'b0;
      Stall_o   = 1'b1;
    end else if (hazard) begin
      bubble    = 1'b1;
      NoOp_o    = 1'b1;
      PCWrite_o = 1'b0;
      Stall_o   = 1'b1;
    end
  end

  always_comb begin
    exD  = exQ;
    memD = memQ;
    wbD  = wbQ;
    if (advance) begin
      exD  = bubble ? '0 : idBundle;
      memD = '{
        regWrite: exQ.regWrite,
        memtoReg: exQ.memtoReg,
        memRead:  exQ.memRead,
        memWrite: exQ.memWrite,
        rd:       exQ.rd
      };
      wbD  = '{
        regWrite: memQ.regWrite,
        memtoReg: memQ.memtoReg,
        rd:       memQ.rd
      };
    end
  end

  always_comb begin
    stallCntD = stallCntQ;
    if (!PCWrite_o && (stallCntQ != CntMax)) begin
      stallCntD = stallCntQ + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      exQ       <= '0;
      memQ      <= '0;
      wbQ       <= '0;
      stallCntQ <= '0;
    end else begin
      exQ       <= exD;
      memQ      <= memD;
      wbQ       <= wbD;
      stallCntQ <= stallCntD;
    end
  end

  assign EX_ALUOp_o     = exQ.aluOp;
  assign EX_ALUSrc_o    = exQ.aluSrc;
  assign EX_RDaddr_o    = exQ.rd;
  assign MEM_MemRead_o  = memQ.memRead;
  assign MEM_MemWrite_o = memQ.memWrite;
  assign MEM_RegWrite_o = memQ.regWrite;
  assign MEM_RDaddr_o   = memQ.rd;
  assign WB_RegWrite_o  = wbQ.regWrite;
  assign WB_MemtoReg_o  = wbQ.memtoReg;
  assign WB_RDaddr_o    = wbQ.rd;
  assign StallCnt_o     = stallCntQ;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Testbench for ctrl_pipe: directed reset / flow / load-use / x0 / memory
// stall / saturation scenarios followed by randomized traffic, all checked
// against a queue-style model of the three pipeline slots.
module tb_ctrl_pipe;

  typedef struct packed {
    logic       regWrite;
    logic       memtoReg;
    logic       memRead;
    logic       memWrite;
    logic       aluSrc;
    logic [1:0] aluOp;
    logic [4:0] rd;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        regWrite = 1'b0, memtoReg = 1'b0, memRead = 1'b0, memWrite = 1'b0;
  logic        aluSrc = 1'b0;
  logic [1:0]  aluOp = 2'd0;
  logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
  logic        memStall = 1'b0;

  logic        noOp, pcWrite, stall;
  logic [1:0]  exAluOp;
  logic        exAluSrc;
  logic [4:0]  exRd;
  logic        memMemRead, memMemWrite, memRegWrite;
  logic [4:0]  memRd;
  logic        wbRegWrite, wbMemtoReg;
  logic [4:0]  wbRd;
  logic [31:0] stallCnt;

  logic        sNoOp, sPcWrite, sStall;
  logic [1:0]  sExAluOp;
  logic        sExAluSrc;
  logic [4:0]  sExRd;
  logic        sMemMemRead, sMemMemWrite, sMemRegWrite;
  logic [4:0]  sMemRd;
  logic        sWbRegWrite, sWbMemtoReg;
  logic [4:0]  sWbRd;
  logic [1:0]  sStallCnt;

  always #5 clk = ~clk;

  ctrl_pipe #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .RegWrite_i(regWrite), .MemtoReg_i(memtoReg), .MemRead_i(memRead),
    .MemWrite_i(memWrite), .ALUSrc_i(aluSrc), .ALUOp_i(aluOp),
    .RS1addr_i(rs1), .RS2addr_i(rs2), .RDaddr_i(rd), .MemStall_i(memStall),
    .NoOp_o(noOp), .PCWrite_o(pcWrite), .Stall_o(stall),
    .EX_ALUOp_o(exAluOp), .EX_ALUSrc_o(exAluSrc), .EX_RDaddr_o(exRd),
    .MEM_MemRead_o(memMemRead), .MEM_MemWrite_o(memMemWrite),
    .MEM_RegWrite_o(memRegWrite), .MEM_RDaddr_o(memRd),
    .WB_RegWrite_o(wbRegWrite), .WB_MemtoReg_o(wbMemtoReg), .WB_RDaddr_o(wbRd),
    .StallCnt_o(stallCnt)
  );

  ctrl_pipe #(.CNT_W(2)) dutSat (
    .clk_i(clk), .rst_i(rst),
    .RegWrite_i(regWrite), .MemtoReg_i(memtoReg), .MemRead_i(memRead),
    .MemWrite_i(memWrite), .ALUSrc_i(aluSrc), .ALUOp_i(aluOp),
    .RS1addr_i(rs1), .RS2addr_i(rs2), .RDaddr_i(rd), .MemStall_i(memStall),
    .NoOp_o(sNoOp), .PCWrite_o(sPcWrite), .Stall_o(sStall),
    .EX_ALUOp_o(sExAluOp), .EX_ALUSrc_o(sExAluSrc), .EX_RDaddr_o(sExRd),
    .MEM_MemRead_o(sMemMemRead), .MEM_MemWrite_o(sMemMemWrite),
    .MEM_RegWrite_o(sMemRegWrite), .MEM_RDaddr_o(sMemRd),
    .WB_RegWrite_o(sWbRegWrite), .WB_MemtoReg_o(sWbMemtoReg), .WB_RDaddr_o(sWbRd),
    .StallCnt_o(sStallCnt)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model: slot 0 = EX, 1 = MEM, 2 = WB; plus total lost issue cycles.
  bundle_t     pipe [3];
  bundle_t     curBundle;
  longint      lostCycles;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bundle_t mk(input logic rw, input logic m2r, input logic mr,
                                 input logic mw, input logic as, input logic [1:0] op,
                                 input logic [4:0] d);
    bundle_t b;
    b.regWrite = rw; b.memtoReg = m2r; b.memRead = mr; b.memWrite = mw;
    b.aluSrc = as; b.aluOp = op; b.rd = d;
    return b;
  endfunction

  function automatic logic modelHazard();
    return pipe[0].memRead && (pipe[0].rd != 5'd0) &&
           ((pipe[0].rd == rs1) || (pipe[0].rd == rs2));
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    lostCycles = 0;
  endtask

  // Apply one cycle of ID inputs at the falling edge, then check every output.
  task automatic drive(input bundle_t b, input logic [4:0] s1, input logic [4:0] s2,
                       input logic ms, input logic rstN);
    logic haz, lost;
    longint sat;
    @(negedge clk);
    rst = rstN;
    regWrite = b.regWrite; memtoReg = b.memtoReg; memRead = b.memRead;
    memWrite = b.memWrite; aluSrc = b.aluSrc; aluOp = b.aluOp; rd = b.rd;
    rs1 = s1; rs2 = s2; memStall = ms;
    curBundle = b;
    #1;
    if (!rstN) clearModel();
    haz  = rstN && !ms && modelHazard();
    lost = rstN && (ms || haz);
    sat  = (lostCycles > 3) ? 3 : lostCycles;
    checkVal("noOp", noOp, haz);
    checkVal("pcWrite", pcWrite, !lost);
    checkVal("stall", stall, lost);
    checkVal("exAluOp", exAluOp, pipe[0].aluOp);
    checkVal("exAluSrc", exAluSrc, pipe[0].aluSrc);
    checkVal("exRd", exRd, pipe[0].rd);
    checkVal("memMemRead", memMemRead, pipe[1].memRead);
    checkVal("memMemWrite", memMemWrite, pipe[1].memWrite);
    checkVal("memRegWrite", memRegWrite, pipe[1].regWrite);
    checkVal("memRd", memRd, pipe[1].rd);
    checkVal("wbRegWrite", wbRegWrite, pipe[2].regWrite);
    checkVal("wbMemtoReg", wbMemtoReg, pipe[2].memtoReg);
    checkVal("wbRd", wbRd, pipe[2].rd);
    checkVal("stallCnt", stallCnt, lostCycles);
    checkVal("satCnt", sStallCnt, sat);
  endtask

  // Clock edge: move the model the way the spec's priority rules say.
  task automatic advance();
    logic haz;
    @(posedge clk);
    if (!rst) begin
      clearModel();
    end else if (memStall) begin
      lostCycles++;
    end else begin
      haz = modelHazard();
      if (haz) lostCycles++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = haz ? '0 : curBundle;
    end
  endtask

  task automatic step(input bundle_t b, input logic [4:0] s1, input logic [4:0] s2,
                      input logic ms);
    drive(b, s1, s2, ms, 1'b1);
    advance();
  endtask

  bundle_t nop, lw5, add6, lw0, rnd;
  longint  cntBefore;

  initial begin
    clearModel();
    nop  = '0;
    lw5  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 5'd5);
    add6 = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 5'd6);
    lw0  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 5'd0);

    // T1: reset from time zero, then release with idle inputs.
    drive(lw5, 5'd5, 5'd5, 1'b1, 1'b0); advance();
    drive(nop, 5'd0, 5'd0, 1'b0, 1'b1); advance();

    // T2: load flows EX -> MEM -> WB.
    step(lw5, 5'd0, 5'd0, 1'b0);
    step(nop, 5'd0, 5'd0, 1'b0);
    drive(nop, 5'd0, 5'd0, 1'b0, 1'b1);
    checkVal("t2MemRead", memMemRead, 1);
    advance();
    drive(nop, 5'd0, 5'd0, 1'b0, 1'b1);
    checkVal("t2WbMemtoReg", wbMemtoReg, 1);
    checkVal("t2WbRd", wbRd, 5);
    advance();

    // T3: load-use after a fresh reset.
    drive(nop, 5'd0, 5'd0, 1'b0, 1'b0); advance();
    step(lw5, 5'd0, 5'd0, 1'b0);
    drive(add6, 5'd5, 5'd1, 1'b0, 1'b1);
    checkVal("t3NoOp", noOp, 1);
    checkVal("t3PcWrite", pcWrite, 0);
    advance();
    drive(add6, 5'd5, 5'd1, 1'b0, 1'b1);
    checkVal("t3BubbleRd", exRd, 0);
    checkVal("t3Cnt", stallCnt, 1);
    advance();
    drive(nop, 5'd0, 5'd0, 1'b0, 1'b1);
    checkVal("t3AddInEx", exRd, 6);
    advance();

    // T4: load to x0 never stalls.
    cntBefore = lostCycles;
    step(lw0, 5'd0, 5'd0, 1'b0);
    drive(add6, 5'd0, 5'd0, 1'b0, 1'b1);
    checkVal("t4PcWrite", pcWrite, 1);
    advance();
    drive(nop, 5'd0, 5'd0, 1'b0, 1'b1);
    checkVal("t4Cnt", stallCnt, cntBefore);
    advance();

    // T5: memory stall for 3 cycles with a pending hazard.
    cntBefore = lostCycles;
    step(lw5, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(add6, 5'd1, 5'd5, 1'b1, 1'b1);
      checkVal("t5NoOp", noOp, 0);
      checkVal("t5FrozenRd", exRd, 5);
      advance();
    end
    drive(add6, 5'd1, 5'd5, 1'b0, 1'b1);
    checkVal("t5BubbleReq", noOp, 1);
    advance();
    drive(add6, 5'd1, 5'd5, 1'b0, 1'b1);
    checkVal("t5Delta", stallCnt, cntBefore + 4);
    advance();

    // T6: saturation of the 2-bit counter.
    drive(nop, 5'd0, 5'd0, 1'b0, 1'b0); advance();
    for (int i = 0; i < 6; i++) step(nop, 5'd0, 5'd0, 1'b1);
    drive(nop, 5'd0, 5'd0, 1'b0, 1'b1);
    checkVal("t6Sat", sStallCnt, 3);
    checkVal("t6Full", stallCnt, 6);
    advance();

    // Randomized traffic, small register range so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      rnd = mk(1'($urandom), 1'($urandom), ($urandom_range(2) == 0), 1'($urandom),
               1'($urandom), 2'($urandom), 5'($urandom_range(7)));
      drive(rnd, 5'($urandom_range(7)), 5'($urandom_range(7)),
            ($urandom_range(4) == 0), ($urandom_range(59) != 0));
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
